// File: rtl/data_ram_pkg.sv
// Shared encodings for the handshaked byte-addressed data RAM: access widths,
// controller states and the byte-offset width helper.
package data_ram_pkg;

  localparam logic [2:0] MW_B   = 3'b000;
  localparam logic [2:0] MW_H   = 3'b001;
  localparam logic [2:0] MW_W   = 3'b010;
  localparam logic [2:0] MW_D   = 3'b011;
  localparam logic [2:0] MW_BU  = 3'b100;
  localparam logic [2:0] MW_HU  = 3'b101;
  localparam logic [2:0] MW_WU  = 3'b110;
  localparam logic [2:0] MW_ILL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Number of byte-offset bits inside one word (DATA_WIDTH is 32 or 64).
  function automatic int calc_off(input int data_width);
    return (data_width == 64) ? 3 : 2;
  endfunction

endpackage

// File: rtl/ram_lane_align.sv
// Byte-lane steering between a memory word and the LSU: extended load data,
// store byte mask, shifted store data and the alignment check.
module ram_lane_align
  import data_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int OFF        = 3
) (
  input  logic [DATA_WIDTH-1:0]   word_i,
  input  logic [OFF-1:0]          offset_i,
  input  logic [2:0]              memwid_i,
  input  logic [DATA_WIDTH-1:0]   store_data_i,
  output logic [DATA_WIDTH-1:0]   load_data_o,
  output logic [DATA_WIDTH/8-1:0] byte_mask_o,
  output logic [DATA_WIDTH-1:0]   store_data_o,
  output logic                    misalign_o
);

  logic [DATA_WIDTH-1:0] shifted;
  logic [63:0]           s64;
  logic [63:0]           ext64;
  logic [7:0]            lanes;

  always_comb begin
    shifted    = word_i >> {offset_i, 3'b000};
    s64        = 64'(shifted);
    ext64      = s64;
    lanes      = 8'hFF;
    misalign_o = 1'b0;
    case (memwid_i)
      MW_B:    ext64 = {{56{s64[7]}}, s64[7:0]};
      MW_H:    ext64 = {{48{s64[15]}}, s64[15:0]};
      MW_W:    ext64 = {{32{s64[31]}}, s64[31:0]};
      MW_BU:   ext64 = {56'd0, s64[7:0]};
      MW_HU:   ext64 = {48'd0, s64[15:0]};
      MW_WU:   ext64 = {32'd0, s64[31:0]};
      default: ext64 = s64;
    endcase
    // Lane count and alignment depend only on the size bits; signedness is irrelevant here.
    case (memwid_i[1:0])
      2'b00: lanes = 8'h01;
      2'b01: begin
        lanes      = 8'h03;
        misalign_o = offset_i[0];
      end
      2'b10: begin
        lanes      = 8'h0F;
        misalign_o = |offset_i[1:0];
      end
      default: begin
        lanes      = 8'hFF;
        misalign_o = |offset_i;
      end
    endcase
    load_data_o  = ext64[DATA_WIDTH-1:0];
    byte_mask_o  = (DATA_WIDTH/8)'({8'h00, lanes} << offset_i);
    store_data_o = store_data_i << {offset_i, 3'b000};
  end

endmodule

// File: rtl/data_ram_hs.sv
// Byte-addressed data RAM with valid/ready request and response channels,
// configurable wait states and load extension / error reporting.
module data_ram_hs
  import data_ram_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [2:0]            req_memwid_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_data_o,
  output logic                  resp_err_o,
  output logic [1:0]            state_dbg_o
);

  localparam int OFF   = calc_off(DATA_WIDTH);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int IW    = ADDR_WIDTH - OFF;
  localparam int WORDS = 2 ** IW;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // Requests are accepted only in IDLE; the response is held unchanged in RESP until taken.
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [2:0]            memwid_q, memwid_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  resp_err_q, resp_err_d;

  logic [DATA_WIDTH-1:0] mem_q [WORDS];

  logic                  do_access;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic                  acc_write;
  logic [2:0]            acc_memwid;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [IW-1:0]         acc_idx;
  logic                  acc_err;
  logic [DATA_WIDTH-1:0] load_data;
  logic [NB-1:0]         byte_mask;
  logic [DATA_WIDTH-1:0] store_shifted;
  logic                  misalign;

  // With no wait states the access happens on the accepting edge, so use the live bus.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_addr   = req_addr_i;
      acc_write  = req_write_i;
      acc_memwid = req_memwid_i;
      acc_wdata  = req_data_i;
    end else begin
      acc_addr   = addr_q;
      acc_write  = write_q;
      acc_memwid = memwid_q;
      acc_wdata  = wdata_q;
    end
  end

  assign acc_idx = acc_addr[ADDR_WIDTH-1:OFF];

  ram_lane_align #(
    .DATA_WIDTH(DATA_WIDTH),
    .OFF       (OFF)
  ) u_align (
    .word_i      (mem_q[acc_idx]),
    .offset_i    (acc_addr[OFF-1:0]),
    .memwid_i    (acc_memwid),
    .store_data_i(acc_wdata),
    .load_data_o (load_data),
    .byte_mask_o (byte_mask),
    .store_data_o(store_shifted),
    .misalign_o  (misalign)
  );

  assign acc_err = (acc_memwid == MW_ILL)
                 || (acc_write && acc_memwid[2])
                 || misalign
                 || ((acc_memwid == MW_D) && (DATA_WIDTH == 32));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    write_d     = write_q;
    memwid_d    = memwid_q;
    wdata_d     = wdata_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    do_access   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          addr_d   = req_addr_i;
          write_d  = req_write_i;
          memwid_d = req_memwid_i;
          wdata_d  = req_data_i;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d   = ST_RESP;
            do_access = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = ST_RESP;
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (do_access) begin
      resp_err_d  = acc_err;
      resp_data_d = (acc_err || acc_write) ? '0 : load_data;
    end
  end

  assign mem_we = do_access && acc_write && !acc_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      memwid_q    <= 3'b000;
      wdata_q     <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      memwid_q    <= memwid_d;
      wdata_q     <= wdata_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (byte_mask[i]) mem_q[acc_idx][8*i +: 8] <= store_shifted[8*i +: 8];
      end
    end
  end

  assign req_ready_o  = (state_q == ST_IDLE);
  assign resp_valid_o = (state_q == ST_RESP);
  assign resp_data_o  = resp_data_q;
  assign resp_err_o   = resp_err_q;
  assign state_dbg_o  = state_q;

endmodule
